// File: rtl/reg_native_arb_pkg.sv
// Shared types and constants for the reg_native arbiter.
package reg_native_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    RESP = 2'd3
  } arb_state_e;

  // Data returned to the requester when the downstream never answers.
  localparam logic [31:0] DEFAULT_TIMEOUT_DATA = 32'hDEAD_BEEF;

  // Width of a counter that must hold 0..cycles-1; never narrower than one bit.
  function automatic int tmo_cnt_width(input int cycles);
    int w;
    w = $clog2(cycles + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/reg_native_arbiter_rr.sv
// Round-robin pick: the first asserted request at or above ptr, wrapping around.
module rr_arbiter #(
  parameter int N  = 2,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [IW-1:0] winner,
  output logic          any_req
);

  // Scan offsets from far to near so the nearest asserted request is the last to overwrite.
  always_comb begin
    winner  = '0;
    any_req = |req;
    for (int off = N - 1; off >= 0; off--) begin
      if (req[(int'(ptr) + off) % N]) winner = IW'((int'(ptr) + off) % N);
    end
  end

endmodule

// File: rtl/reg_native_arbiter.sv
// Shares one downstream reg_native port among N_REQ upstream masters, one
// transaction at a time, with a per-transaction timeout that forces an error
// response so a hung slave cannot lock up an upstream master.
//
// Handshake: every vld/rdy pair transfers when both are high at a rising clk
// edge; vld, once raised, stays up with stable fields until that edge. The one
// exception is down_req_vld, which is withdrawn when the timeout fires.
module reg_native_arbiter
  import reg_native_arb_pkg::*;
#(
  parameter int                    N_REQ          = 2,
  parameter int                    ADDR_WIDTH     = 64,
  parameter int                    DATA_WIDTH     = 32,
  parameter int                    TIMEOUT_CYCLES = 255,
  parameter logic [DATA_WIDTH-1:0] TIMEOUT_DATA   = DATA_WIDTH'(DEFAULT_TIMEOUT_DATA)
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [N_REQ-1:0]                     up_req_vld,
  output logic [N_REQ-1:0]                     up_req_rdy,
  input  logic [N_REQ-1:0]                     up_wr_en,
  input  logic [N_REQ-1:0]                     up_rd_en,
  input  logic [N_REQ-1:0][ADDR_WIDTH-1:0]     up_addr,
  input  logic [N_REQ-1:0][DATA_WIDTH-1:0]     up_wr_data,
  output logic [N_REQ-1:0]                     up_ack_vld,
  input  logic [N_REQ-1:0]                     up_ack_rdy,
  output logic                                 up_ack_err,
  output logic [DATA_WIDTH-1:0]                up_rd_data,
  output logic                                 down_req_vld,
  input  logic                                 down_req_rdy,
  output logic                                 down_wr_en,
  output logic                                 down_rd_en,
  output logic [ADDR_WIDTH-1:0]                down_addr,
  output logic [DATA_WIDTH-1:0]                down_wr_data,
  input  logic                                 down_ack_vld,
  output logic                                 down_ack_rdy,
  input  logic [DATA_WIDTH-1:0]                down_rd_data,
  output logic                                 busy,
  output logic [$clog2(N_REQ)-1:0]             grant_id,
  output logic                                 timeout_pulse,
  output logic [7:0]                           timeout_cnt,
  output arb_state_e                           state_dbg
);

  localparam int                IDW      = $clog2(N_REQ);
  localparam int                TW       = tmo_cnt_width(TIMEOUT_CYCLES);
  localparam logic [TW-1:0]     TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [IDW-1:0]    LAST_ID  = IDW'(N_REQ - 1);

  arb_state_e                state_q, state_d;
  logic [IDW-1:0]            rr_ptr_q;
  logic [IDW-1:0]            grant_q;
  logic [ADDR_WIDTH-1:0]     addr_q;
  logic                      wr_en_q;
  logic                      rd_en_q;
  logic [DATA_WIDTH-1:0]     wr_data_q;
  logic [DATA_WIDTH-1:0]     rd_data_q;
  logic                      err_q;
  logic [TW-1:0]             tmo_q;
  logic                      pulse_q;
  logic [7:0]                tcnt_q;

  logic [IDW-1:0]            winner;
  logic                      any_req;
  logic                      in_flight;
  logic                      tmo_hit;
  logic                      accept;
  logic                      ack_take;
  logic                      tmo_fire;
  logic                      resp_done;

  rr_arbiter #(.N(N_REQ), .IW(IDW)) u_rr (
    .req     (up_req_vld),
    .ptr     (rr_ptr_q),
    .winner  (winner),
    .any_req (any_req)
  );

  // Transaction events; a real downstream ack beats a timeout in the same cycle.
  always_comb begin
    in_flight = (state_q == REQ) || (state_q == WAIT);
    tmo_hit   = (TIMEOUT_CYCLES != 0) && in_flight && (tmo_q == TMO_LAST);
    accept    = (state_q == IDLE) && any_req;
    ack_take  = (state_q == WAIT) && down_ack_vld;
    tmo_fire  = tmo_hit && !ack_take;
    resp_done = (state_q == RESP) && up_ack_rdy[grant_q];
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = REQ;
      REQ: begin
        if (tmo_fire)          state_d = RESP;
        else if (down_req_rdy) state_d = WAIT;
      end
      WAIT:    if (ack_take || tmo_fire) state_d = RESP;
      RESP:    if (resp_done) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Request capture on the upstream accept edge, and round-robin pointer advance.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q    <= '0;
      wr_en_q   <= 1'b0;
      rd_en_q   <= 1'b0;
      wr_data_q <= '0;
      grant_q   <= '0;
      rr_ptr_q  <= '0;
    end else begin
      if (accept) begin
        addr_q    <= up_addr[winner];
        wr_en_q   <= up_wr_en[winner];
        rd_en_q   <= up_rd_en[winner];
        wr_data_q <= up_wr_data[winner];
        grant_q   <= winner;
      end
      if (resp_done) rr_ptr_q <= (grant_q == LAST_ID) ? '0 : grant_q + 1'b1;
    end
  end

  // Response capture, per-transaction timeout counter and timeout statistics.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data_q <= '0;
      err_q     <= 1'b0;
      tmo_q     <= '0;
      pulse_q   <= 1'b0;
      tcnt_q    <= '0;
    end else begin
      if (accept)                                  tmo_q <= '0;
      else if (in_flight && (TIMEOUT_CYCLES != 0)) tmo_q <= tmo_q + 1'b1;
      if (ack_take) begin
        rd_data_q <= down_rd_data;
        err_q     <= 1'b0;
      end else if (tmo_fire) begin
        rd_data_q <= TIMEOUT_DATA;
        err_q     <= 1'b1;
      end
      pulse_q <= tmo_fire;
      if (tmo_fire && (tcnt_q != 8'hFF)) tcnt_q <= tcnt_q + 8'd1;
    end
  end

  // Port drive: one-hot upstream handshakes, downstream request from latched fields.
  always_comb begin
    up_req_rdy = '0;
    if (accept) up_req_rdy[winner] = 1'b1;
    up_ack_vld = '0;
    if (state_q == RESP) up_ack_vld[grant_q] = 1'b1;
    down_req_vld = (state_q == REQ) && !tmo_hit;
    down_ack_rdy = (state_q == IDLE) || (state_q == WAIT);
  end

  assign down_addr     = addr_q;
  assign down_wr_en    = wr_en_q;
  assign down_rd_en    = rd_en_q;
  assign down_wr_data  = wr_data_q;
  assign up_rd_data    = rd_data_q;
  assign up_ack_err    = err_q;
  assign busy          = (state_q != IDLE);
  assign grant_id      = grant_q;
  assign timeout_pulse = pulse_q;
  assign timeout_cnt   = tcnt_q;
  assign state_dbg     = state_q;

endmodule

// File: tb/tb_reg_native_arbiter.sv
// Bench for reg_native_arbiter: directed scenarios plus randomized traffic.
module tb_reg_native_arbiter;
  import reg_native_arb_pkg::*;

  localparam int N  = 2;
  localparam int AW = 64;
  localparam int DW = 32;
  localparam int T  = 8;
  localparam logic [DW-1:0] TMO_DATA = 32'hDEAD_BEEF;

  logic                   clk;
  logic                   rst;
  logic [N-1:0]           up_req_vld;
  logic [N-1:0]           up_req_rdy;
  logic [N-1:0]           up_wr_en;
  logic [N-1:0]           up_rd_en;
  logic [N-1:0][AW-1:0]   up_addr;
  logic [N-1:0][DW-1:0]   up_wr_data;
  logic [N-1:0]           up_ack_vld;
  logic [N-1:0]           up_ack_rdy;
  logic                   up_ack_err;
  logic [DW-1:0]          up_rd_data;
  logic                   down_req_vld;
  logic                   down_req_rdy;
  logic                   down_wr_en;
  logic                   down_rd_en;
  logic [AW-1:0]          down_addr;
  logic [DW-1:0]          down_wr_data;
  logic                   down_ack_vld;
  logic                   down_ack_rdy;
  logic [DW-1:0]          down_rd_data;
  logic                   busy;
  logic [$clog2(N)-1:0]   grant_id;
  logic                   timeout_pulse;
  logic [7:0]             timeout_cnt;
  arb_state_e             state_dbg;

  reg_native_arbiter #(
    .N_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
    .TIMEOUT_CYCLES(T), .TIMEOUT_DATA(TMO_DATA)
  ) dut (
    .clk(clk), .rst(rst),
    .up_req_vld(up_req_vld), .up_req_rdy(up_req_rdy),
    .up_wr_en(up_wr_en), .up_rd_en(up_rd_en),
    .up_addr(up_addr), .up_wr_data(up_wr_data),
    .up_ack_vld(up_ack_vld), .up_ack_rdy(up_ack_rdy),
    .up_ack_err(up_ack_err), .up_rd_data(up_rd_data),
    .down_req_vld(down_req_vld), .down_req_rdy(down_req_rdy),
    .down_wr_en(down_wr_en), .down_rd_en(down_rd_en),
    .down_addr(down_addr), .down_wr_data(down_wr_data),
    .down_ack_vld(down_ack_vld), .down_ack_rdy(down_ack_rdy),
    .down_rd_data(down_rd_data),
    .busy(busy), .grant_id(grant_id),
    .timeout_pulse(timeout_pulse), .timeout_cnt(timeout_cnt),
    .state_dbg(state_dbg)
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: round-robin pointer, timeout tally, expected response data.
  int            m_ptr;
  int            m_tcnt;
  logic [DW-1:0] exp_q[$];

  // Requester-side transaction fields.
  logic [AW-1:0] ra  [N];
  logic          rw  [N];
  logic [DW-1:0] rwd [N];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int rr_pick(input logic [N-1:0] mask);
    for (int off = 0; off < N; off++) begin
      if (mask[(m_ptr + off) % N]) return (m_ptr + off) % N;
    end
    return -1;
  endfunction

  task automatic drive_fields(input bit keep);
    for (int i = 0; i < N; i++) begin
      if (!keep) begin
        ra[i]  = {$urandom, $urandom};
        rw[i]  = 1'($urandom_range(0, 1));
        rwd[i] = $urandom;
      end
      up_addr[i]    = ra[i];
      up_wr_en[i]   = rw[i];
      up_rd_en[i]   = !rw[i];
      up_wr_data[i] = rwd[i];
    end
  endtask

  // Driver: one whole transaction. Called in an IDLE cycle; returns in the next IDLE cycle.
  // req_lat/ack_lat: downstream stall cycles before accept/ack; bp: upstream response stall.
  task automatic transact(input logic [N-1:0] mask, input bit keep, input int req_lat,
                          input int ack_lat, input int bp, input logic [DW-1:0] slv_data);
    int            g;
    int            total;
    int            r;
    bit            tmo;
    logic [DW-1:0] exp_d;
    drive_fields(keep);
    up_req_vld = mask;
    g     = rr_pick(mask);
    total = req_lat + ack_lat + 2;
    tmo   = (total > T);
    r     = tmo ? T + 1 : total + 1;
    exp_d = '0;
    exp_q.push_back(tmo ? TMO_DATA : slv_data);
    #1;
    chk("req_rdy_grant", up_req_rdy, 64'(1) << g);
    for (int c = 1; c <= r; c++) begin
      tick();
      down_req_rdy = (c == req_lat + 1);
      down_ack_vld = !tmo && (c == total);
      down_rd_data = (c == total) ? slv_data : $urandom;
      #1;
      if (c == 1) begin
        chk("down_req_vld", down_req_vld, 1);
        chk("down_addr", down_addr, ra[g]);
        chk("down_wr_en", down_wr_en, rw[g]);
        chk("down_rd_en", down_rd_en, !rw[g]);
        chk("down_wr_data", down_wr_data, rwd[g]);
        chk("grant_id_req", grant_id, g);
        chk("busy_req", busy, 1);
        chk("req_rdy_busy", up_req_rdy, 0);
      end
      if (c == r - 1) chk("ack_vld_early", up_ack_vld, 0);
      if (c == r) begin
        exp_d = exp_q.pop_front();
        chk("ack_vld", up_ack_vld, 64'(1) << g);
        chk("ack_err", up_ack_err, tmo);
        chk("rd_data", up_rd_data, exp_d);
        chk("tmo_pulse", timeout_pulse, tmo);
        chk("grant_id_resp", grant_id, g);
        chk("down_vld_resp", down_req_vld, 0);
      end
    end
    down_req_rdy = 1'b0;
    down_ack_vld = 1'b0;
    if (tmo) m_tcnt = (m_tcnt < 255) ? m_tcnt + 1 : 255;
    for (int b = 1; b <= bp; b++) begin
      tick();
      chk("bp_ack_vld", up_ack_vld, 64'(1) << g);
      chk("bp_rd_data", up_rd_data, exp_d);
      chk("bp_no_grant", up_req_rdy, 0);
      chk("bp_pulse", timeout_pulse, 0);
    end
    up_ack_rdy = N'(1) << g;
    tick();
    up_ack_rdy = '0;
    m_ptr = (g + 1) % N;
    chk("idle_busy", busy, 0);
    chk("timeout_cnt", timeout_cnt, m_tcnt);
    up_req_vld = '0;
  endtask

  task automatic reset_and_check();
    rst = 1'b1;
    up_req_vld = '0; up_ack_rdy = '0; down_req_rdy = 1'b0; down_ack_vld = 1'b0;
    tick();
    chk("rst_state", state_dbg, IDLE);
    chk("rst_busy", busy, 0);
    chk("rst_grant_id", grant_id, 0);
    chk("rst_tcnt", timeout_cnt, 0);
    chk("rst_ack_vld", up_ack_vld, 0);
    chk("rst_ack_err", up_ack_err, 0);
    chk("rst_rd_data", up_rd_data, 0);
    chk("rst_down_vld", down_req_vld, 0);
    chk("rst_down_addr", down_addr, 0);
    chk("rst_down_wr", down_wr_en, 0);
    chk("rst_req_rdy", up_req_rdy, 0);
    chk("rst_pulse", timeout_pulse, 0);
    tick();
    rst = 1'b0;
    m_ptr  = 0;
    m_tcnt = 0;
    exp_q.delete();
  endtask

  initial begin
    rst = 1'b1;
    up_req_vld = '0; up_wr_en = '0; up_rd_en = '0; up_addr = '0; up_wr_data = '0;
    up_ack_rdy = '0; down_req_rdy = 1'b0; down_ack_vld = 1'b0; down_rd_data = '0;
    m_ptr = 0; m_tcnt = 0;
    for (int i = 0; i < N; i++) begin ra[i] = '0; rw[i] = 1'b0; rwd[i] = '0; end
    reset_and_check();

    // Both requesters continuously requesting: grants alternate starting at 0.
    for (int k = 0; k < 4; k++)
      transact(2'b11, 0, $urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(0, 1), $urandom);

    // Directed write from requester 0, slave accepts after 2 stall cycles.
    ra[0] = 64'h10; rw[0] = 1'b1; rwd[0] = 32'hFFFF_FFFF;
    transact(2'b01, 1, 2, 1, 0, $urandom);

    // Read from requester 1 returning a known word.
    ra[1] = {$urandom, $urandom}; rw[1] = 1'b0; rwd[1] = $urandom;
    transact(2'b10, 1, 0, 1, 0, 32'h1234_5678);

    // Slave never acks: timeout error response.
    transact(2'b01, 0, 0, 100, 0, $urandom);

    // Late ack arriving in IDLE must be swallowed.
    chk("idle_ack_rdy", down_ack_rdy, 1);
    down_ack_vld = 1'b1; down_rd_data = 32'h5555_5555;
    tick();
    down_ack_vld = 1'b0;
    chk("stray_busy", busy, 0);
    chk("stray_ack_vld", up_ack_vld, 0);
    chk("stray_rd_data", up_rd_data, TMO_DATA);

    // Upstream holds off the response for 5 cycles, then the other requester wins.
    transact(2'b11, 0, 1, 1, 5, $urandom);
    transact(2'b11, 0, 0, 0, 0, $urandom);

    // Slave never accepts the request: timeout while still in REQ.
    transact(2'b10, 0, 9, 0, 0, $urandom);

    // Randomized traffic, some of it long enough to time out.
    for (int k = 0; k < 16; k++)
      transact(2'($urandom_range(1, 3)), 0, $urandom_range(0, 3), $urandom_range(0, 5),
               $urandom_range(0, 2), $urandom);

    // Leave the pointer at 1, then reset in the middle of a requester-1 transaction.
    transact(2'b01, 0, 0, 0, 0, $urandom);
    drive_fields(0);
    up_req_vld = 2'b10;
    tick();
    up_req_vld = '0;
    down_req_rdy = 1'b1;
    chk("mid_down_vld", down_req_vld, 1);
    chk("mid_grant", grant_id, 1);
    tick();
    down_req_rdy = 1'b0;
    chk("mid_wait_busy", busy, 1);
    chk("mid_ack_rdy", down_ack_rdy, 1);
    reset_and_check();
    repeat (3) begin
      tick();
      chk("post_rst_no_ack", up_ack_vld, 0);
    end
    // Pointer is back at 0, so requester 0 wins.
    transact(2'b11, 0, 1, 1, 0, $urandom);

    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

endmodule

// File: doc/reg_native_arbiter.md
Name: reg_native_arbiter

Overview:
- Shares one downstream reg_native_if (regmst ext port, or a regslv upstream port) among N_REQ upstream masters, e.g. the APB-driven regmst and a debug/JTAG master.
- Arbitration is round-robin, with one outstanding transaction at a time.
- A per-transaction timeout returns an error response so that a hung regslv never deadlocks an upstream master.
- Sits between the upstream masters and the regslv tree; it is transparent to the register map.

Parameters:
- N_REQ, 2, number of upstream requesters (2..8).
- ADDR_WIDTH, 64, address width.
- DATA_WIDTH, 32, data width.
- TIMEOUT_CYCLES, 255, cycles allowed in REQ+WAIT before forced error response; 0 disables the timeout.
- TIMEOUT_DATA, 32'hDEAD_BEEF, rd_data returned on timeout.

Ports:
- clk  in  1  single clock.
- rst  in  1  synchronous, active-high reset.
- up_req_vld  in  N_REQ  per-requester request valid.
- up_req_rdy  out  N_REQ  per-requester request accept.
- up_wr_en  in  N_REQ  per-requester write enable.
- up_rd_en  in  N_REQ  per-requester read enable.
- up_addr  in  N_REQ x ADDR_WIDTH  per-requester address.
- up_wr_data  in  N_REQ x DATA_WIDTH  per-requester write data.
- up_ack_vld  out  N_REQ  per-requester response valid.
- up_ack_rdy  in  N_REQ  per-requester response accept.
- up_ack_err  out  1  response is a timeout error (valid with up_ack_vld).
- up_rd_data  out  DATA_WIDTH  response data, shared by all requesters.
- down_req_vld  out  1  downstream request valid.
- down_req_rdy  in  1  downstream request accept.
- down_wr_en  out  1  downstream write enable.
- down_rd_en  out  1  downstream read enable.
- down_addr  out  ADDR_WIDTH  downstream address.
- down_wr_data  out  DATA_WIDTH  downstream write data.
- down_ack_vld  in  1  downstream response valid.
- down_ack_rdy  out  1  downstream response accept.
- down_rd_data  in  DATA_WIDTH  downstream response data.
- busy  out  1  arbiter state is not IDLE.
- grant_id  out  clog2(N_REQ)  index of the current or last granted requester.
- timeout_pulse  out  1  one-cycle pulse when a timeout fires.
- timeout_cnt  out  8  saturating count of timeouts.

Behaviour:
- Reset (rst=1 at a clock edge):
  - state=IDLE, rr_ptr=0, grant_id=0, timeout_cnt=0.
  - All vld/rdy outputs 0, up_ack_err=0, data/address registers 0.
  - rst aborts any in-flight transaction; the aborted transaction gets no upstream response.
- Handshake rule: a transfer occurs when vld&rdy are both high at a clock edge. Request fields are sampled only on the accept edge.
- IDLE state:
  - Winner = first index i with up_req_vld[i], scanning from rr_ptr upward with wrap.
  - up_req_rdy[winner]=1 combinationally in the same cycle; all other up_req_rdy bits are 0.
  - On that edge: latch addr, wr_en, rd_en, wr_data; grant_id<=winner; go to REQ.
  - down_ack_rdy=1 in IDLE; stray downstream acks arriving in IDLE are discarded.
- REQ state:
  - down_req_vld=1 with the latched fields.
  - down_req_rdy=1 -> WAIT.
  - Latency: a request accepted at edge k appears on down_req_vld in cycle k+1.
- WAIT state:
  - down_ack_rdy=1.
  - down_ack_vld=1 -> latch down_rd_data, up_ack_err<=0, go to RESP.
- RESP state:
  - up_ack_vld[grant_id]=1, holding up_rd_data and up_ack_err stable.
  - up_ack_rdy[grant_id]=1 -> IDLE, rr_ptr<=(grant_id+1) mod N_REQ.
  - A new arbitration can win in the first IDLE cycle, so back-to-back transactions take 1 IDLE cycle minimum.
- Timeout:
  - The counter clears on entry to REQ and increments every cycle spent in REQ or WAIT.
  - When it reaches TIMEOUT_CYCLES: up_rd_data<=TIMEOUT_DATA, up_ack_err<=1, timeout_pulse=1 for one cycle, timeout_cnt+=1 (saturating at 255), go to RESP.
  - down_req_vld drops even if not yet accepted; this is the only permitted withdrawal.
  - A genuine down_ack_vld in the same cycle as the timeout wins: normal response, no timeout.
  - With TIMEOUT_CYCLES=0 the timeout is disabled and the arbiter waits forever.
- Write transactions also return down_rd_data unchanged.
- Requesters other than the winner keep up_req_rdy=0 and their inputs are ignored; a requester may drop up_req_vld before it is granted.
- busy=1 in REQ, WAIT and RESP.

Decomposition:
- Package reg_native_arb_pkg:
  - arb_state_e enum {IDLE, REQ, WAIT, RESP}.
  - TIMEOUT counter width function.
  - Default TIMEOUT_DATA constant.
- Sub-module rr_arbiter (N parameter): inputs req vector and ptr; outputs winner index and any_req.

Test Plan:
- Single write, requester 0: addr=0x10, data=0xFFFFFFFF, regslv ready after 2 cycles -> down_addr=0x10, down_wr_en=1, up_ack_vld[0] one cycle after down ack, up_ack_err=0.
- Simultaneous requests: both requesters hold vld continuously, rr_ptr=0 -> grant order 0,1,0,1 across 4 transactions; grant_id matches each response.
- Read data path: regslv returns 0x12345678 to requester 1 -> up_rd_data=0x12345678 on up_ack_vld[1]; up_ack_vld[0] stays 0.
- Timeout: TIMEOUT_CYCLES=8, down_ack_vld held at 0 -> exactly 8 cycles after REQ entry, up_ack_vld=1, up_ack_err=1, up_rd_data=0xDEADBEEF; timeout_cnt=1; a late ack in IDLE is discarded.
- Backpressure: up_ack_rdy low for 5 cycles -> response held stable and no new grant; then IDLE, and the next grant goes to the other requester.
- Reset mid-transaction: rst asserted in WAIT -> next cycle all outputs 0, state IDLE, rr_ptr=0.
